// File: rtl/sr_latch_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_writer_pkg
// Brief    : State encoding, default timing and phase-counter width for the
//            SR latch writer.
// Revision : 1.0
// ============================================================================
package sr_latch_writer_pkg;

   localparam int C_DEFAULT_SETUP_CYCLES = 1;
   localparam int C_DEFAULT_PULSE_CYCLES = 2;
   localparam int C_DEFAULT_HOLD_CYCLES  = 1;
   localparam int C_CNT_W                = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_CHECK = 3'd4
   } state_e;

   // A phase of N cycles counts N-1 down to 0.
   function automatic logic [C_CNT_W-1:0] phase_load(input int n);
      return C_CNT_W'(n - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_writer_phase_counter.sv
`default_nettype none
// ============================================================================
// Module   : phase_counter
// Brief    : Loadable saturating down-counter with a zero flag, timing each
//            phase of the SR latch writer.
// Revision : 1.0
// ============================================================================
module phase_counter
   import sr_latch_writer_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic [C_CNT_W-1:0] load_val_i,
   output logic               zero_o
);

   logic [C_CNT_W-1:0] count_q;
   logic [C_CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - C_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sr_latch_writer.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_writer
// Brief    : Sequences setup / enable pulse / hold / check to write one bit
//            into an enabled SR latch and verify the latch feedback.
//            Optional: SR_LATCH_WRITER_SKIP_REDUNDANT_EN skips the pulse when
//            the latch already holds the requested value.
// Revision : 1.0
// ============================================================================
module sr_latch_writer
   import sr_latch_writer_pkg::*;
#(
   parameter int SETUP_CYCLES = C_DEFAULT_SETUP_CYCLES,
   parameter int PULSE_CYCLES = C_DEFAULT_PULSE_CYCLES,
   parameter int HOLD_CYCLES  = C_DEFAULT_HOLD_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic req_valid,
   input  logic req_value,
   output logic req_ready,
   output logic enabled,
   output logic set,
   output logic reset_out,
   input  logic Q,
   input  logic notQ,
   output logic done,
   output logic error
);

   state_e               state_q;
   state_e               state_d;
   logic                 value_q;
   logic                 value_d;

   logic                 en_q,      en_d;
   logic                 set_q,     set_d;
   logic                 rst_out_q, rst_out_d;
   logic                 done_q,    done_d;
   logic                 error_q,   error_d;
   logic                 ready_q,   ready_d;

   logic                 w_skip;
   logic                 w_drive;
   logic                 w_cnt_load;
   logic [C_CNT_W-1:0]   w_cnt_load_val;
   logic                 w_cnt_zero;

`ifdef SR_LATCH_WRITER_SKIP_REDUNDANT_EN
   assign w_skip = (Q == req_value) && (notQ == ~Q);
`else
   assign w_skip = 1'b0;
`endif

   phase_counter u_phase_counter (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (w_cnt_load),
      .load_val_i (w_cnt_load_val),
      .zero_o     (w_cnt_zero)
   );

   always_comb begin
      state_d        = state_q;
      value_d        = value_q;
      w_cnt_load     = 1'b0;
      w_cnt_load_val = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               value_d = req_value;
               if (w_skip) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d        = ST_SETUP;
                  w_cnt_load     = 1'b1;
                  w_cnt_load_val = phase_load(SETUP_CYCLES);
               end
            end
         end
         ST_SETUP: begin
            if (w_cnt_zero) begin
               state_d        = ST_PULSE;
               w_cnt_load     = 1'b1;
               w_cnt_load_val = phase_load(PULSE_CYCLES);
            end
         end
         ST_PULSE: begin
            if (w_cnt_zero) begin
               state_d        = ST_HOLD;
               w_cnt_load     = 1'b1;
               w_cnt_load_val = phase_load(HOLD_CYCLES);
            end
         end
         ST_HOLD: begin
            if (w_cnt_zero) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so each one is a flop.
   always_comb begin
      w_drive   = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
      en_d      = (state_d == ST_PULSE);
      set_d     = w_drive & value_d;
      rst_out_d = w_drive & ~value_d;
      done_d    = (state_d == ST_CHECK);
      error_d   = done_d & ((Q != value_d) | (notQ == Q));
      ready_d   = (state_d == ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         value_q   <= 1'b0;
         en_q      <= 1'b0;
         set_q     <= 1'b0;
         rst_out_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         en_q      <= en_d;
         set_q     <= set_d;
         rst_out_q <= rst_out_d;
         done_q    <= done_d;
         error_q   <= error_d;
         ready_q   <= ready_d;
      end
   end

   assign req_ready = ready_q;
   assign enabled   = en_q;
   assign set       = set_q;
   assign reset_out = rst_out_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule
`default_nettype wire
